// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// default link constants (50 MHz clock, 115200 baud, 16x oversampling).
package uart_pkg;

   localparam int UART_CLK_DIV    = 27;
   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   // PARITY is only reachable when UART_RX_PARITY_EN is defined.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_receiver_tick_counter.sv
// Modulo-N counter with enable and synchronous clear. Wrap is a
// combinational one-cycle pulse in the enabled cycle that takes Q from
// N-1 back to 0. Clear takes priority over Enable.
module tick_counter #(
   parameter int N = 16
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Enable,
   input  logic                 Clear,
   output logic [$clog2(N)-1:0] Q,
   output logic                 Wrap
);
   localparam int W = $clog2(N);
   localparam logic [W-1:0] LAST = W'(N - 1);

   // Count enabled cycles modulo N.
   always_ff @(posedge Clock) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of block evaluation order.
      if (Reset || Clear) begin
         Q <= '0;
      end else if (Enable) begin
         Q <= (Q == LAST) ? '0 : Q + 1'b1;
      end
   end

   assign Wrap = Enable && (Q == LAST);

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: 2-flop input synchronizer, baud tick
// generator, mid-bit sampling FSM, stop-bit check and one-cycle result
// strobes. Optional even parity bit is enabled by defining the macro
// UART_RX_PARITY_EN; without it ParityError is tied to 0.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = UART_CLK_DIV,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] DataOut,
   output logic                 DataValid,
   output logic                 FrameError,
   output logic                 ParityError,
   output logic                 Busy
);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   rx_state_t              state, state_next;
   logic                   rx_meta, rx_sync;
   logic                   tick;
   logic [$clog2(CLK_DIV)-1:0] div_q_unused;
   logic [SW-1:0]          samp_q;
   logic                   samp_wrap;
   logic [BW-1:0]          bit_cnt;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   shift_en, load_out, valid_set, ferr_set;
`ifdef UART_RX_PARITY_EN
   logic                   par_en, perr_set, parity_bad;
`endif

   // Bring the asynchronous line into the clock domain; idle level is 1.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= Rx;
         rx_sync <= rx_meta;
      end
   end

   // Baud tick generator; held at 0 while idle so a frame starts phase-aligned.
   tick_counter #(.N(CLK_DIV)) u_baud (
      .Clock  (Clock),
      .Reset  (Reset),
      .Enable (1'b1),
      .Clear  (state == IDLE),
      .Q      (div_q_unused),
      .Wrap   (tick)
   );

   // Ticks within the current bit; restarts on every state change.
   tick_counter #(.N(OVERSAMPLE)) u_sample (
      .Clock  (Clock),
      .Reset  (Reset),
      .Enable (tick),
      .Clear  (state_next != state),
      .Q      (samp_q),
      .Wrap   (samp_wrap)
   );

   // FSM state register.
   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state and per-cycle datapath controls.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a
      // variable unassigned, which would otherwise infer a latch.
      state_next = state;
      shift_en   = 1'b0;
      load_out   = 1'b0;
      valid_set  = 1'b0;
      ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en     = 1'b0;
      perr_set   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!rx_sync) state_next = START;
         end
         START: begin
            // Mid start bit: a high line here was only a glitch.
            if (tick && samp_q == HALF_LAST) state_next = rx_sync ? IDLE : DATA;
         end
         DATA: begin
            if (samp_wrap) begin
               shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
               if (bit_cnt == LAST_BIT) state_next = PARITY;
`else
               if (bit_cnt == LAST_BIT) state_next = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (samp_wrap) begin
               par_en     = 1'b1;
               state_next = STOP;
            end
         end
`endif
         STOP: begin
            if (samp_wrap) begin
               load_out = 1'b1;
               if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
                  if (parity_bad) perr_set  = 1'b1;
                  else            valid_set = 1'b1;
`else
                  valid_set = 1'b1;
`endif
                  state_next = IDLE;
               end else begin
                  ferr_set   = 1'b1;
                  state_next = BREAK;
               end
            end
         end
         BREAK: begin
            // A held-low line must return high before a new start bit counts.
            if (rx_sync) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Shift register, bit counter, output word and result strobes.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         bit_cnt    <= '0;
         shift_q    <= '0;
         DataOut    <= '0;
         DataValid  <= 1'b0;
         FrameError <= 1'b0;
      end else begin
         DataValid  <= valid_set;
         FrameError <= ferr_set;
         if (state != DATA) bit_cnt <= '0;
         else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
         if (shift_en) shift_q <= {rx_sync, shift_q[DATA_BITS-1:1]};
         if (load_out) DataOut <= shift_q;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Even parity: the data bits plus the parity bit carry an even count of ones.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         parity_bad  <= 1'b0;
         ParityError <= 1'b0;
      end else begin
         ParityError <= perr_set;
         if (state == START) parity_bad <= 1'b0;
         else if (par_en)    parity_bad <= (rx_sync != ^shift_q);
      end
   end
`else
   assign ParityError = 1'b0;
`endif

   assign Busy = (state != IDLE);

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Oversampling UART receive path: synchronizes the asynchronous serial input, detects the start bit, samples each data bit at mid-bit using a modulo-N tick counter, and checks the stop bit. It presents each received byte on a parallel output with a one-cycle valid strobe. It sits between the board's RX pin and the byte-level consumer (FIFO or command parser), and is the receiving end of the team's UART link.

## Interface
- CLK_DIV, 27: Clock cycles per oversample tick (50 MHz / (115200 × 16)); must be ≥ 2.
- OVERSAMPLE, 16: Ticks per bit period; even, ≥ 4.
- DATA_BITS, 8: Data bits per frame, LSB first; range 5–9.
- Clock  input  1  System clock; all logic on the rising edge.
- Reset  input  1  Synchronous, active-high reset.
- Rx  input  1  Asynchronous serial line; idle high.
- DataOut  output  DATA_BITS  Last received word; holds until the next frame completes.
- DataValid  output  1  One-cycle pulse when a frame completes with a good stop bit (and good parity, if enabled).
- FrameError  output  1  One-cycle pulse when the stop bit is sampled low.
- ParityError  output  1  One-cycle pulse on parity mismatch; constant 0 when parity is compiled out.
- Busy  output  1  High in every state except IDLE.

## Operation
- Rx passes through a 2-flop synchronizer. Both flops reset to 1.
- The tick generator is a mod-CLK_DIV counter. It emits a one-cycle tick when it wraps, and is cleared whenever the FSM is in IDLE.
- The sample counter is mod-OVERSAMPLE and advances on each tick. It is cleared on every state change.
- FSM states: IDLE, START, DATA, PARITY (only when compiled in), STOP, BREAK.
- IDLE: when the synchronized Rx is 0, go to START.
- START: after OVERSAMPLE/2 ticks, re-sample. If Rx is 0, go to DATA. If Rx is 1, treat it as a glitch and return to IDLE with no output pulse.
- DATA: sample once every OVERSAMPLE ticks and shift the bit in LSB-first. After DATA_BITS samples, go to PARITY or STOP.
- PARITY: sample after OVERSAMPLE ticks and compare against even parity of the data, then go to STOP.
- STOP: sample after OVERSAMPLE ticks, then load DataOut.
  - Rx = 1: pulse DataValid (suppressed when there is a parity error, which pulses ParityError instead), then go to IDLE.
  - Rx = 0: pulse FrameError, then go to BREAK.
- BREAK: wait until Rx = 1, then go to IDLE. This prevents a held-low line from retriggering.
- DataValid, FrameError and ParityError are mutually exclusive within a frame.

## Timing
- Reset values:
  - DataOut = 0; DataValid, FrameError, ParityError, Busy = 0.
  - FSM is in IDLE; both counters are 0; synchronizer flops are 1.
- Reset asserted mid-frame aborts the frame immediately with no pulse.
- Rx falling edge to IDLE→START transition: 2 cycles (synchronizer) + 1 cycle.
- Stop-bit sample point: (OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE)·CLK_DIV cycles after entering START, plus OVERSAMPLE·CLK_DIV more with parity enabled.
- DataValid is registered and asserts in the cycle after the stop sample. DataOut updates in that same cycle.
- A new start bit is accepted in the cycle after returning to IDLE. Frames may be back-to-back with no idle gap.

## Configuration
- Macro: UART_RX_PARITY_EN.
- Defined: PARITY state present; one even-parity bit is expected between the data and stop bits; ParityError is live.
- Undefined: no PARITY state; the frame is start + DATA_BITS + stop; ParityError is tied to 0.

## Structure
- Package uart_pkg holds:
  - the FSM state enum (rx_state_t);
  - default constants UART_CLK_DIV = 27, UART_OVERSAMPLE = 16, UART_DATA_BITS = 8.
- One sub-module: tick_counter, a parameterized modulo-N counter with Enable, synchronous active-high Clear, Q, and a Wrap pulse.
  - It is instantiated twice: once as the baud tick generator and once as the sample counter.

## Test plan
All scenarios use CLK_DIV = 4, OVERSAMPLE = 16, DATA_BITS = 8, i.e. 64 clocks per bit.
- Send frame 0xA5 with a good stop bit → DataOut = 0xA5; exactly one DataValid pulse, 610 cycles after Rx falls (±1); FrameError = 0.
- Send 0x00 then 0xFF back-to-back with no idle gap → two DataValid pulses carrying 0x00 then 0xFF.
- Drive a 20-cycle low glitch on an idle line → no pulses; Busy high for about 35 cycles, then IDLE.
- Send 0x3C with the stop bit low, then hold Rx low for 500 cycles → one FrameError pulse; no DataValid; Busy stays high until Rx returns to 1.
- Assert Reset during bit 4 of a frame, then send 0x5A → no output from the aborted frame; 0x5A is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with a wrong parity bit → one ParityError pulse; no DataValid; DataOut = 0x07.
